nesting_stack_controller: RTL and testbench
===========================================

# nesting_stack_controller

Sequencer for the parser's nesting-context block RAM. Accepts push/pop requests from the nesting tracker (one entry per open object/array: array flag plus pair/member count), keeps the top of stack in a register so pop data is always visible combinationally, and drives a single-port, 1-cycle-read-latency BRAM for the entries underneath. Detects overflow and underflow and halts in a fault state rather than corrupting parser context.

## Interface
Parameters:
- DEPTH, 1024, maximum number of stacked entries (top register plus DEPTH-1 BRAM words)
- WIDTH, 18, entry width ({inArray, count[16:0]})

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- enb  in  1  global enable; requests are ignored when low
- pushReq  in  1  push pushData this cycle
- popReq  in  1  pop top entry this cycle
- pushData  in  WIDTH  entry to push
- popData  out  WIDTH  current top entry, combinational from top register
- ready  out  1  requests are accepted this cycle
- curDepth  out  $clog2(DEPTH)+1  number of valid entries
- fault  out  1  sticky; set on overflow or underflow
- overflow, underflow  out  1 each  sticky cause flags
- highWater  out  $clog2(DEPTH)+1  maximum curDepth since reset (see Configuration)
- bramAddr  out  $clog2(DEPTH)  BRAM address
- bramWe  out  1  BRAM write enable
- bramWdata  out  WIDTH  BRAM write data
- bramRdata  in  WIDTH  BRAM read data, valid the cycle after address

## Operation
- Entry k (0 = bottom) lives in BRAM[k] for k < curDepth-1; entry curDepth-1 lives in topReg.
- Request accepted when enb && ready && (pushReq || popReq).
- States: IDLE, REFILL, FAULT. Reset → IDLE, curDepth 0, topReg 0, all flags 0.
- IDLE, push only, curDepth == 0: topReg ← pushData, curDepth ← 1, no BRAM access.
- IDLE, push only, 0 < curDepth < DEPTH: bramWe=1, bramAddr=curDepth-1, bramWdata=topReg; topReg ← pushData; curDepth+1.
- IDLE, push only, curDepth == DEPTH: no change to stack; overflow ← 1, fault ← 1, → FAULT.
- IDLE, pop only, curDepth == 1: curDepth ← 0, topReg ← 0, stay IDLE.
- IDLE, pop only, curDepth ≥ 2: bramAddr=curDepth-2, bramWe=0; curDepth-1; → REFILL.
- IDLE, pop only, curDepth == 0: underflow ← 1, fault ← 1, → FAULT.
- IDLE, push and pop, curDepth ≥ 1: replace top: topReg ← pushData, depth unchanged, no BRAM access. At curDepth 0: treated as underflow.
- REFILL: topReg ← bramRdata, → IDLE. Completes regardless of enb (read data is valid one cycle only).
- FAULT: ready 0, all requests ignored, exit only by rst.
- bramWe is 0 whenever enb is 0; bramAddr is a don't-care when no access.

## Timing
- ready = (state == IDLE); low exactly one cycle after each pop that leaves depth ≥ 1.
- popData reflects topReg: new value visible the cycle after a push; after a deep pop, valid the cycle after REFILL (two cycles after acceptance).
- curDepth updates on the edge ending the accepting cycle.
- Fault flags assert the cycle after the offending request and hold until rst.
- rst mid-REFILL: REFILL abandoned, → IDLE with empty stack; bramRdata ignored.
- Back-to-back pushes: one per cycle. Back-to-back pops: one per two cycles.

## Configuration
- NESTING_HWM_EN defined: highWater register, reset 0, updated to curDepth whenever curDepth exceeds it (same edge as curDepth update).
- Undefined: highWater tied to '0; no register synthesized. Port list unchanged in both cases.

## Structure
- ParserPkg: StackCtrlState enum {IDLE, REFILL, FAULT}; StackEntry typedef (packed: inArray, count[16:0]); NESTING_STACK_DEPTH constant = 1024.
- One sub-module: nesting_stack_bram (single-port, registered read, DEPTH-1 × WIDTH), instantiated inside the controller; the bram* ports also remain exposed for trace/verification.

## Test plan
- Reset, push 0x00005, 0x20003, 0x00007 → curDepth 3, popData 0x00007, BRAM[0]=0x00005, BRAM[1]=0x20003.
- From that state pop → ready 0 for one cycle, then popData 0x20003, curDepth 2; pop again → popData 0x00005, curDepth 1.
- Push and pop together at curDepth 2 with pushData 0x1FFFF → curDepth 2, popData 0x1FFFF, bramWe never asserted.
- Fill to DEPTH then push once more → overflow 1, fault 1, ready 0; further pops ignored until rst.
- Pop at curDepth 0 after reset → underflow 1, FAULT; assert rst during a REFILL → curDepth 0, state IDLE, flags 0.
- With NESTING_HWM_EN: push 5, pop 3, push 1 → highWater 5; without it highWater stays 0.

Source files
------------

// File: rtl/nesting_stack_controller_pkg.sv
// Shared types and constants for the parser nesting-context stack.
package ParserPkg;

    localparam int NESTING_STACK_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FAULT  = 2'd2
    } StackCtrlState;

    // One open object/array: array flag plus member/pair count.
    typedef struct packed {
        logic        inArray;
        logic [16:0] count;
    } StackEntry;

endpackage

// File: rtl/nesting_stack_controller_bram.sv
// Single-port block RAM, read-first, one cycle registered read latency.
// Holds the stack entries underneath the top-of-stack register.
module nesting_stack_bram #(
    parameter int WORDS = 1023,
    parameter int AW    = 10,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // Write on we; read data always registered from the current address.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nesting_stack_controller.sv
// Nesting-context stack sequencer: top entry held in a register, deeper
// entries in a single-port BRAM. Overflow/underflow park the block in FAULT.
// Optional feature: define NESTING_HWM_EN to build the high-water register.
module nesting_stack_controller
    import ParserPkg::*;
#(
    parameter int DEPTH = NESTING_STACK_DEPTH,
    parameter int WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       pushReq,
    input  logic                       popReq,
    input  logic [WIDTH-1:0]           pushData,
    output logic [WIDTH-1:0]           popData,
    output logic                       ready,
    output logic [$clog2(DEPTH):0]     curDepth,
    output logic                       fault,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     highWater,
    output logic [$clog2(DEPTH)-1:0]   bramAddr,
    output logic                       bramWe,
    output logic [WIDTH-1:0]           bramWdata,
    input  logic [WIDTH-1:0]           bramRdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    StackCtrlState    state, nextState;
    logic [WIDTH-1:0] topReg, nextTop;
    logic [DW-1:0]    nextDepth;
    logic             setOvf, setUnf;
    logic             accept, isEmpty, isFull;
    logic [WIDTH-1:0] memRdata;

    assign ready     = (state == IDLE);
    assign accept    = enb && ready && (pushReq || popReq);
    assign isEmpty   = (curDepth == '0);
    assign isFull    = (curDepth == DW'(DEPTH));
    assign popData   = topReg;
    assign fault     = overflow | underflow;

    // Next-state, stack update and BRAM command decode.
    always_comb begin
        nextState = state;
        nextDepth = curDepth;
        nextTop   = topReg;
        setOvf    = 1'b0;
        setUnf    = 1'b0;
        bramWe    = 1'b0;
        bramAddr  = AW'(curDepth - DW'(1));
        bramWdata = topReg;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (pushReq && popReq) begin
                        // Replace top in place; no BRAM traffic.
                        if (isEmpty) begin
                            setUnf    = 1'b1;
                            nextState = FAULT;
                        end else begin
                            nextTop = pushData;
                        end
                    end else if (pushReq) begin
                        if (isEmpty) begin
                            nextTop   = pushData;
                            nextDepth = DW'(1);
                        end else if (isFull) begin
                            setOvf    = 1'b1;
                            nextState = FAULT;
                        end else begin
                            // Spill current top to BRAM[curDepth-1].
                            bramWe    = 1'b1;
                            nextTop   = pushData;
                            nextDepth = curDepth + DW'(1);
                        end
                    end else begin
                        if (isEmpty) begin
                            setUnf    = 1'b1;
                            nextState = FAULT;
                        end else if (curDepth == DW'(1)) begin
                            nextDepth = '0;
                            nextTop   = '0;
                        end else begin
                            // Fetch the new top; it lands in REFILL.
                            bramAddr  = AW'(curDepth - DW'(2));
                            nextDepth = curDepth - DW'(1);
                            nextState = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                nextTop   = bramRdata;
                nextState = IDLE;
            end
            FAULT: begin
                nextState = FAULT;
            end
            default: nextState = IDLE;
        endcase
    end

    // State, stack pointer, top register and sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            curDepth  <= '0;
            topReg    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= nextState;
            curDepth  <= nextDepth;
            topReg    <= nextTop;
            overflow  <= overflow | setOvf;
            underflow <= underflow | setUnf;
        end
    end

`ifdef NESTING_HWM_EN
    logic [DW-1:0] highWaterReg;

    // Track the deepest stack seen since reset, same edge as curDepth.
    always_ff @(posedge clk) begin
        if (rst)
            highWaterReg <= '0;
        else if (nextDepth > highWaterReg)
            highWaterReg <= nextDepth;
    end

    assign highWater = highWaterReg;
`else
    assign highWater = '0;
`endif

    nesting_stack_bram #(
        .WORDS(DEPTH - 1),
        .AW   (AW),
        .WIDTH(WIDTH)
    ) uBram (
        .clk  (clk),
        .we   (bramWe),
        .addr (bramAddr),
        .wdata(bramWdata),
        .rdata(memRdata)
    );

    // Refill data arrives on bramRdata; the local array must agree with it.
    always_ff @(posedge clk) begin
        if (!rst && state == REFILL)
            assert (memRdata == bramRdata);
    end

endmodule

// File: tb/tb_nesting_stack_controller.sv
// Directed bench for nesting_stack_controller with an external BRAM model.
module tb_nesting_stack_controller;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 18;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = AW + 1;

`ifdef NESTING_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, enb, pushReq, popReq;
    logic [WIDTH-1:0] pushData, popData, bramWdata, bramRdata;
    logic             ready, fault, overflow, underflow, bramWe;
    logic [DW-1:0]    curDepth, highWater;
    logic [AW-1:0]    bramAddr;

    int checks  = 0;
    int errors  = 0;
    int weCount = 0;

    logic [WIDTH-1:0] bmem [DEPTH-1];

    always #5 clk = ~clk;

    nesting_stack_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .pushReq  (pushReq),
        .popReq   (popReq),
        .pushData (pushData),
        .popData  (popData),
        .ready    (ready),
        .curDepth (curDepth),
        .fault    (fault),
        .overflow (overflow),
        .underflow(underflow),
        .highWater(highWater),
        .bramAddr (bramAddr),
        .bramWe   (bramWe),
        .bramWdata(bramWdata),
        .bramRdata(bramRdata)
    );

    // External single-port BRAM model plus write counter.
    always @(posedge clk) begin
        if (bramWe) begin
            bmem[bramAddr] <= bramWdata;
            weCount        <= weCount + 1;
        end
        bramRdata <= bmem[bramAddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic push, input logic pop, input logic [WIDTH-1:0] d);
        pushReq  = push;
        popReq   = pop;
        pushData = d;
        @(posedge clk);
        #1;
        pushReq  = 1'b0;
        popReq   = 1'b0;
    endtask

    task automatic doReset;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int we0;
        rst = 1'b0; enb = 1'b1; pushReq = 1'b0; popReq = 1'b0; pushData = '0;
        doReset();

        // Reset state
        check("rst_depth", 32'(curDepth), 0);
        check("rst_ready", 32'(ready), 1);
        check("rst_fault", 32'(fault), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_pop", 32'(popData), 0);
        check("rst_hwm", 32'(highWater), 0);

        // Three pushes
        we0 = weCount;
        cyc(1, 0, 18'h00005);
        check("p1_depth", 32'(curDepth), 1);
        check("p1_pop", 32'(popData), 32'h5);
        check("p1_noWe", 32'(weCount - we0), 0);
        cyc(1, 0, 18'h20003);
        cyc(1, 0, 18'h00007);
        check("p3_depth", 32'(curDepth), 3);
        check("p3_pop", 32'(popData), 32'h7);
        check("p3_bram0", 32'(bmem[0]), 32'h5);
        check("p3_bram1", 32'(bmem[1]), 32'h20003);
        check("p3_we", 32'(weCount - we0), 2);
        check("p3_hwm", 32'(highWater), HWM_ON ? 3 : 0);

        // Enable low: request ignored
        enb = 1'b0;
        cyc(1, 0, 18'h00011);
        check("enb_depth", 32'(curDepth), 3);
        check("enb_we", 32'(weCount - we0), 2);
        enb = 1'b1;

        // Deep pop, second pop held through REFILL must be ignored
        cyc(0, 1, '0);
        check("pop1_ready", 32'(ready), 0);
        check("pop1_depth", 32'(curDepth), 2);
        cyc(0, 1, '0);
        check("pop1_ready2", 32'(ready), 1);
        check("pop1_depth2", 32'(curDepth), 2);
        check("pop1_data", 32'(popData), 32'h20003);
        cyc(0, 1, '0);
        check("pop2_depth", 32'(curDepth), 1);
        check("pop2_ready", 32'(ready), 0);
        cyc(0, 0, '0);
        check("pop2_data", 32'(popData), 32'h5);

        // Replace top at depth 2
        cyc(1, 0, 18'h00009);
        check("p9_depth", 32'(curDepth), 2);
        we0 = weCount;
        cyc(1, 1, 18'h1FFFF);
        check("rep_depth", 32'(curDepth), 2);
        check("rep_pop", 32'(popData), 32'h1FFFF);
        check("rep_noWe", 32'(weCount - we0), 0);
        check("rep_ready", 32'(ready), 1);

        // Drain: deep pop then last pop
        cyc(0, 1, '0); cyc(0, 0, '0);
        check("drain_data", 32'(popData), 32'h5);
        cyc(0, 1, '0);
        check("drain_depth", 32'(curDepth), 0);
        check("drain_pop", 32'(popData), 0);
        check("drain_ready", 32'(ready), 1);

        // High-water: push 5, pop 3, push 1
        doReset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, WIDTH'(i));
        for (int i = 0; i < 3; i++) begin cyc(0, 1, '0); cyc(0, 0, '0); end
        check("hwm_pop", 32'(popData), 2);
        cyc(1, 0, 18'h0000A);
        check("hwm_depth", 32'(curDepth), 3);
        check("hwm_val", 32'(highWater), HWM_ON ? 5 : 0);

        // Underflow by pop at depth 0
        doReset();
        cyc(0, 1, '0);
        check("unf_flag", 32'(underflow), 1);
        check("unf_fault", 32'(fault), 1);
        check("unf_ovf", 32'(overflow), 0);
        check("unf_ready", 32'(ready), 0);
        cyc(1, 0, 18'h00005);
        check("unf_ignored", 32'(curDepth), 0);

        // Underflow by push+pop at depth 0
        doReset();
        cyc(1, 1, 18'h00003);
        check("unf2_flag", 32'(underflow), 1);
        check("unf2_depth", 32'(curDepth), 0);

        // Reset during REFILL
        doReset();
        cyc(1, 0, 18'h00021);
        cyc(1, 0, 18'h00022);
        cyc(0, 1, '0);
        check("rr_inRefill", 32'(ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rr_depth", 32'(curDepth), 0);
        check("rr_ready", 32'(ready), 1);
        check("rr_pop", 32'(popData), 0);
        check("rr_fault", 32'(fault), 0);
        cyc(0, 0, '0);
        check("rr_pop2", 32'(popData), 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, WIDTH'(i));
        check("full_depth", 32'(curDepth), DEPTH);
        check("full_pop", 32'(popData), DEPTH - 1);
        check("full_bram0", 32'(bmem[0]), 0);
        check("full_bramTop", 32'(bmem[DEPTH-2]), DEPTH - 2);
        check("full_ready", 32'(ready), 1);
        cyc(1, 0, 18'h3FFFF);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_fault", 32'(fault), 1);
        check("ovf_ready", 32'(ready), 0);
        check("ovf_depth", 32'(curDepth), DEPTH);
        check("ovf_pop", 32'(popData), DEPTH - 1);
        cyc(0, 1, '0);
        cyc(0, 1, '0);
        check("ovf_popIgn", 32'(curDepth), DEPTH);
        check("ovf_sticky", 32'(overflow), 1);
        doReset();
        check("ovf_rstFault", 32'(fault), 0);
        check("ovf_rstDepth", 32'(curDepth), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
